// File: rtl/rasteriser_pkg.sv
// Shared types, widths and small helpers for the triangle setup block.
package rasteriser_pkg;

    localparam int COORD_W = 16;   // unsigned 12.4 vertex coordinate
    localparam int STEP_W  = 17;   // signed difference of two coordinates
    localparam int EDGE_W  = 25;   // signed 20.4 edge value
    localparam int AREA_W  = 24;   // unsigned 20.4 doubled area
    localparam int PIX_W   = 12;   // integer pixel index
    localparam int FRAC_W  = 4;    // fractional bits of a coordinate
    localparam int PROD_W  = 2 * STEP_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        MUL   = 3'd2,
        FIX   = 3'd3,
        OUT   = 3'd4
    } state_e;

    function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        logic [PIX_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        logic [PIX_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // a - b of two unsigned coordinates, always representable in STEP_W bits
    function automatic logic signed [STEP_W-1:0] sdiff(input logic [COORD_W-1:0] a,
                                                       input logic [COORD_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/tri_setup_if.sv
// Producer/consumer bundle for the triangle setup block.
interface tri_setup_if;
    import rasteriser_pkg::*;

    logic [COORD_W-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
    logic               valid_in;
    logic               busy_out;
    logic [AREA_W-1:0]  area;
    logic [STEP_W-1:0]  dl_w0_col, dl_w1_col, dl_w2_col;
    logic [STEP_W-1:0]  dl_w0_row, dl_w1_row, dl_w2_row;
    logic [EDGE_W-1:0]  w0_row, w1_row, w2_row;
    logic [PIX_W-1:0]   x_min, y_min, x_max, y_max;
    logic               valid_out;
    logic               busy_in;

    // master: vertex producer and result consumer side
    modport master (
        output v0x, v0y, v1x, v1y, v2x, v2y, valid_in, busy_in,
        input  busy_out, area, dl_w0_col, dl_w1_col, dl_w2_col,
               dl_w0_row, dl_w1_row, dl_w2_row, w0_row, w1_row, w2_row,
               x_min, y_min, x_max, y_max, valid_out
    );

    // slave: the setup engine side
    modport slave (
        input  v0x, v0y, v1x, v1y, v2x, v2y, valid_in, busy_in,
        output busy_out, area, dl_w0_col, dl_w1_col, dl_w2_col,
               dl_w0_row, dl_w1_row, dl_w2_row, w0_row, w1_row, w2_row,
               x_min, y_min, x_max, y_max, valid_out
    );

endinterface

// File: rtl/edge_mul.sv
// Shared signed 17x17 multiplier used for every edge-function product.
module edge_mul
    import rasteriser_pkg::*;
(
    input  logic signed [STEP_W-1:0] a_i,
    input  logic signed [STEP_W-1:0] b_i,
    output logic signed [PROD_W-1:0] p_o
);

    assign p_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: bbox, edge steps and edge start values through one multiplier.
//
//   state | meaning
//   IDLE  | waiting for a vertex set; vertices latched on accept
//   SETUP | differences and bounding box registered
//   MUL   | eight products, two per edge function plus two for the area
//   FIX   | orientation fix-up, degenerate / off-screen drop
//   OUT   | result presented until the consumer takes it
module tri_setup
    import rasteriser_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [COORD_W-1:0] v0x_i,
    input  logic [COORD_W-1:0] v0y_i,
    input  logic [COORD_W-1:0] v1x_i,
    input  logic [COORD_W-1:0] v1y_i,
    input  logic [COORD_W-1:0] v2x_i,
    input  logic [COORD_W-1:0] v2y_i,
    input  logic               valid_i,
    output logic               busy_o,
    output logic [AREA_W-1:0]  area_o,
    output logic [STEP_W-1:0]  dl_w0_col_o,
    output logic [STEP_W-1:0]  dl_w1_col_o,
    output logic [STEP_W-1:0]  dl_w2_col_o,
    output logic [STEP_W-1:0]  dl_w0_row_o,
    output logic [STEP_W-1:0]  dl_w1_row_o,
    output logic [STEP_W-1:0]  dl_w2_row_o,
    output logic [EDGE_W-1:0]  w0_row_o,
    output logic [EDGE_W-1:0]  w1_row_o,
    output logic [EDGE_W-1:0]  w2_row_o,
    output logic [PIX_W-1:0]   x_min_o,
    output logic [PIX_W-1:0]   y_min_o,
    output logic [PIX_W-1:0]   x_max_o,
    output logic [PIX_W-1:0]   y_max_o,
    output logic               valid_o,
    input  logic               busy_i
);

    localparam logic [PIX_W-1:0] X_LIM = PIX_W'(SCREEN_W - 1);
    localparam logic [PIX_W-1:0] Y_LIM = PIX_W'(SCREEN_H - 1);

    state_e state_q, state_d;
    logic [2:0] cnt_q;

    logic [COORD_W-1:0] vx_q [3];
    logic [COORD_W-1:0] vy_q [3];

    // Edge K runs from vertex a=(K+1)%3 to b=(K+2)%3.
    // ed_* = b - a, pd_* = p - a, a2_* = v2 - v0 (area operands).
    logic signed [STEP_W-1:0] ed_x_q [3];
    logic signed [STEP_W-1:0] ed_y_q [3];
    logic signed [STEP_W-1:0] pd_x_q [3];
    logic signed [STEP_W-1:0] pd_y_q [3];
    logic signed [STEP_W-1:0] a2_x_q, a2_y_q;

    logic signed [PROD_W-1:0] acc_q;
    logic signed [EDGE_W-1:0] res_q [4];   // w0, w1, w2, area before fix-up

    logic [PIX_W-1:0]  xmin_q, ymin_q, xmax_q, ymax_q;
    logic [AREA_W-1:0] area_q;
    logic [STEP_W-1:0] col_q [3];
    logic [STEP_W-1:0] row_q [3];
    logic [EDGE_W-1:0] w_q [3];

    logic [PIX_W-1:0]   bx_min, bx_max, by_min, by_max;
    logic [COORD_W-1:0] px, py;

    logic signed [STEP_W-1:0] mul_a, mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W:0]   diff_full, diff_sh;
    logic signed [EDGE_W-1:0] edge_val;

    logic                     neg, drop;
    logic signed [EDGE_W-1:0] area_abs;

    // Bounding box from the integer parts of the latched vertices
    always_comb begin
        bx_min = min3(vx_q[0][COORD_W-1:FRAC_W], vx_q[1][COORD_W-1:FRAC_W], vx_q[2][COORD_W-1:FRAC_W]);
        bx_max = max3(vx_q[0][COORD_W-1:FRAC_W], vx_q[1][COORD_W-1:FRAC_W], vx_q[2][COORD_W-1:FRAC_W]);
        by_min = min3(vy_q[0][COORD_W-1:FRAC_W], vy_q[1][COORD_W-1:FRAC_W], vy_q[2][COORD_W-1:FRAC_W]);
        by_max = max3(vy_q[0][COORD_W-1:FRAC_W], vy_q[1][COORD_W-1:FRAC_W], vy_q[2][COORD_W-1:FRAC_W]);
        px     = {bx_min, {FRAC_W{1'b0}}};
        py     = {by_min, {FRAC_W{1'b0}}};
    end

    // Multiplier operand select: even count is (bx-ax)*(py-ay), odd is (by-ay)*(px-ax)
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (cnt_q[2:1] == 2'd3) begin
            mul_a = cnt_q[0] ? ed_y_q[2] : ed_x_q[2];
            mul_b = cnt_q[0] ? a2_x_q    : a2_y_q;
        end else begin
            mul_a = cnt_q[0] ? ed_y_q[cnt_q[2:1]] : ed_x_q[cnt_q[2:1]];
            mul_b = cnt_q[0] ? pd_x_q[cnt_q[2:1]] : pd_y_q[cnt_q[2:1]];
        end
    end

    edge_mul u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    // Full-precision edge difference, dropped to 20.4 by an arithmetic shift
    always_comb begin
        diff_full = (PROD_W+1)'(acc_q) - (PROD_W+1)'(prod);
        diff_sh   = diff_full >>> FRAC_W;
        edge_val  = diff_sh[EDGE_W-1:0];
    end

    // Orientation and drop decisions taken in FIX
    always_comb begin
        neg      = res_q[3][EDGE_W-1];
        area_abs = neg ? -res_q[3] : res_q[3];
        drop     = (res_q[3] == '0) || (xmin_q > X_LIM) || (ymin_q > Y_LIM);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_i) state_d = SETUP;
            SETUP:   state_d = MUL;
            MUL:     if (cnt_q == 3'd7) state_d = FIX;
            FIX:     state_d = drop ? IDLE : OUT;
            OUT:     if (!busy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and product counter
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == MUL) ? cnt_q + 3'd1 : 3'd0;
        end
    end

    // Datapath: vertex capture, differences, products and fix-up
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < 3; k++) begin
                vx_q[k]   <= '0;
                vy_q[k]   <= '0;
                ed_x_q[k] <= '0;
                ed_y_q[k] <= '0;
                pd_x_q[k] <= '0;
                pd_y_q[k] <= '0;
                col_q[k]  <= '0;
                row_q[k]  <= '0;
                w_q[k]    <= '0;
            end
            for (int k = 0; k < 4; k++) res_q[k] <= '0;
            a2_x_q <= '0;
            a2_y_q <= '0;
            acc_q  <= '0;
            xmin_q <= '0;
            ymin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
            area_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (valid_i) begin
                    vx_q[0] <= v0x_i;
                    vy_q[0] <= v0y_i;
                    vx_q[1] <= v1x_i;
                    vy_q[1] <= v1y_i;
                    vx_q[2] <= v2x_i;
                    vy_q[2] <= v2y_i;
                end
                SETUP: begin
                    for (int k = 0; k < 3; k++) begin
                        ed_x_q[k] <= sdiff(vx_q[(k+2)%3], vx_q[(k+1)%3]);
                        ed_y_q[k] <= sdiff(vy_q[(k+2)%3], vy_q[(k+1)%3]);
                        pd_x_q[k] <= sdiff(px, vx_q[(k+1)%3]);
                        pd_y_q[k] <= sdiff(py, vy_q[(k+1)%3]);
                    end
                    a2_x_q <= sdiff(vx_q[2], vx_q[0]);
                    a2_y_q <= sdiff(vy_q[2], vy_q[0]);
                    xmin_q <= bx_min;
                    ymin_q <= by_min;
                    xmax_q <= (bx_max > X_LIM) ? X_LIM : bx_max;
                    ymax_q <= (by_max > Y_LIM) ? Y_LIM : by_max;
                end
                MUL: begin
                    if (!cnt_q[0]) acc_q <= prod;
                    else           res_q[cnt_q[2:1]] <= edge_val;
                end
                FIX: if (!drop) begin
                    area_q <= area_abs[AREA_W-1:0];
                    for (int k = 0; k < 3; k++) begin
                        w_q[k]   <= neg ? -res_q[k] : res_q[k];
                        col_q[k] <= neg ? ed_y_q[k] : -ed_y_q[k];
                        row_q[k] <= neg ? -ed_x_q[k] : ed_x_q[k];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign valid_o     = (state_q == OUT);
    assign area_o      = area_q;
    assign dl_w0_col_o = col_q[0];
    assign dl_w1_col_o = col_q[1];
    assign dl_w2_col_o = col_q[2];
    assign dl_w0_row_o = row_q[0];
    assign dl_w1_row_o = row_q[1];
    assign dl_w2_row_o = row_q[2];
    assign w0_row_o    = w_q[0];
    assign w1_row_o    = w_q[1];
    assign w2_row_o    = w_q[2];
    assign x_min_o     = xmin_q;
    assign y_min_o     = ymin_q;
    assign x_max_o     = xmax_q;
    assign y_max_o     = ymax_q;

endmodule

// File: tb/tb_tri_setup.sv
// Bench for tri_setup: directed corner cases plus random triangles against a reference model.
module tb_tri_setup;
    import rasteriser_pkg::*;

    localparam int W = 640;
    localparam int H = 480;

    logic clk = 1'b0;
    logic rst_n;

    tri_setup_if bus();

    always #5 clk = ~clk;

    tri_setup #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clock_i     (clk),
        .reset_i     (rst_n),
        .v0x_i       (bus.v0x),
        .v0y_i       (bus.v0y),
        .v1x_i       (bus.v1x),
        .v1y_i       (bus.v1y),
        .v2x_i       (bus.v2x),
        .v2y_i       (bus.v2y),
        .valid_i     (bus.valid_in),
        .busy_o      (bus.busy_out),
        .area_o      (bus.area),
        .dl_w0_col_o (bus.dl_w0_col),
        .dl_w1_col_o (bus.dl_w1_col),
        .dl_w2_col_o (bus.dl_w2_col),
        .dl_w0_row_o (bus.dl_w0_row),
        .dl_w1_row_o (bus.dl_w1_row),
        .dl_w2_row_o (bus.dl_w2_row),
        .w0_row_o    (bus.w0_row),
        .w1_row_o    (bus.w1_row),
        .w2_row_o    (bus.w2_row),
        .x_min_o     (bus.x_min),
        .y_min_o     (bus.y_min),
        .x_max_o     (bus.x_max),
        .y_max_o     (bus.y_max),
        .valid_o     (bus.valid_out),
        .busy_i      (bus.busy_in)
    );

    int n_vec = 0;
    int n_err = 0;

    int tvx [3];
    int tvy [3];

    logic        e_drop;
    logic [23:0] e_area;
    logic [24:0] e_w   [3];
    logic [16:0] e_col [3];
    logic [16:0] e_row [3];
    logic [11:0] e_xmin, e_ymin, e_xmax, e_ymax;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint edge_fn(input longint ax, input longint ay, input longint bx,
                                       input longint by, input longint qx, input longint qy);
        return (bx - ax) * (qy - ay) - (by - ay) * (qx - ax);
    endfunction

    function automatic longint fold25(input longint f);
        logic [24:0] t;
        t = 25'(f >>> 4);
        return longint'($signed(t));
    endfunction

    // Reference: bbox, edge functions at the bbox corner, orientation fix-up, drop rule
    task automatic model();
        int xmn, xmx, ymn, ymx;
        longint qx, qy, ar;
        longint w [3];
        longint col [3];
        longint row [3];
        bit neg;
        xmn = tvx[0] / 16; xmx = xmn;
        ymn = tvy[0] / 16; ymx = ymn;
        for (int i = 1; i < 3; i++) begin
            if (tvx[i] / 16 < xmn) xmn = tvx[i] / 16;
            if (tvx[i] / 16 > xmx) xmx = tvx[i] / 16;
            if (tvy[i] / 16 < ymn) ymn = tvy[i] / 16;
            if (tvy[i] / 16 > ymx) ymx = tvy[i] / 16;
        end
        if (xmx > W - 1) xmx = W - 1;
        if (ymx > H - 1) ymx = H - 1;
        qx = longint'(xmn) * 16;
        qy = longint'(ymn) * 16;
        for (int k = 0; k < 3; k++) begin
            int a, b;
            a = (k + 1) % 3;
            b = (k + 2) % 3;
            w[k]   = fold25(edge_fn(tvx[a], tvy[a], tvx[b], tvy[b], qx, qy));
            col[k] = tvy[a] - tvy[b];
            row[k] = tvx[b] - tvx[a];
        end
        ar  = fold25(edge_fn(tvx[0], tvy[0], tvx[1], tvy[1], tvx[2], tvy[2]));
        neg = (ar < 0);
        e_drop = (ar == 0) || (xmn > W - 1) || (ymn > H - 1);
        if (neg) begin
            ar = -ar;
            for (int k = 0; k < 3; k++) begin
                w[k] = -w[k]; col[k] = -col[k]; row[k] = -row[k];
            end
        end
        e_area = 24'(ar);
        for (int k = 0; k < 3; k++) begin
            e_w[k]   = 25'(w[k]);
            e_col[k] = 17'(col[k]);
            e_row[k] = 17'(row[k]);
        end
        e_xmin = 12'(xmn); e_ymin = 12'(ymn); e_xmax = 12'(xmx); e_ymax = 12'(ymx);
    endtask

    task automatic check_outputs(input string p);
        check({p, "_area"},   32'(bus.area),      32'(e_area));
        check({p, "_w0"},     32'(bus.w0_row),    32'(e_w[0]));
        check({p, "_w1"},     32'(bus.w1_row),    32'(e_w[1]));
        check({p, "_w2"},     32'(bus.w2_row),    32'(e_w[2]));
        check({p, "_col0"},   32'(bus.dl_w0_col), 32'(e_col[0]));
        check({p, "_col1"},   32'(bus.dl_w1_col), 32'(e_col[1]));
        check({p, "_col2"},   32'(bus.dl_w2_col), 32'(e_col[2]));
        check({p, "_row0"},   32'(bus.dl_w0_row), 32'(e_row[0]));
        check({p, "_row1"},   32'(bus.dl_w1_row), 32'(e_row[1]));
        check({p, "_row2"},   32'(bus.dl_w2_row), 32'(e_row[2]));
        check({p, "_xmin"},   32'(bus.x_min),     32'(e_xmin));
        check({p, "_ymin"},   32'(bus.y_min),     32'(e_ymin));
        check({p, "_xmax"},   32'(bus.x_max),     32'(e_xmax));
        check({p, "_ymax"},   32'(bus.y_max),     32'(e_ymax));
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        tvx[0] = x0; tvy[0] = y0;
        tvx[1] = x1; tvy[1] = y1;
        tvx[2] = x2; tvy[2] = y2;
    endtask

    // Present the vertex set; returns at the falling edge just after the accept edge
    task automatic present(input bit stall);
        model();
        @(negedge clk);
        check("idle_before", 32'(bus.busy_out), 32'd0);
        bus.v0x = 16'(tvx[0]); bus.v0y = 16'(tvy[0]);
        bus.v1x = 16'(tvx[1]); bus.v1y = 16'(tvy[1]);
        bus.v2x = 16'(tvx[2]); bus.v2y = 16'(tvy[2]);
        bus.valid_in = 1'b1;
        bus.busy_in  = stall;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.v0x = 16'($urandom); bus.v0y = 16'($urandom);
        bus.v1x = 16'($urandom); bus.v1y = 16'($urandom);
        bus.v2x = 16'($urandom); bus.v2y = 16'($urandom);
        check("busy_after_accept", 32'(bus.busy_out), 32'd1);
    endtask

    task automatic run_tri(input string p, input int stall);
        int   first;
        logic busy10;
        present(stall > 0);
        first  = 0;
        busy10 = 1'b1;
        for (int k = 1; k <= 12 && first == 0; k++) begin
            @(negedge clk);
            if (k == 10) busy10 = bus.busy_out;
            if (bus.valid_out) first = k;
        end
        if (e_drop) begin
            check({p, "_no_valid"}, 32'(first), 32'd0);
            check({p, "_idle_at10"}, 32'(busy10), 32'd0);
            bus.busy_in = 1'b0;
        end else begin
            check({p, "_latency"}, 32'(first), 32'd10);
            if (first != 0) begin
                check_outputs(p);
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check({p, "_hold_valid"}, 32'(bus.valid_out), 32'd1);
                    check_outputs({p, "_hold"});
                end
                bus.busy_in = 1'b0;
                @(negedge clk);
                check({p, "_done_valid"}, 32'(bus.valid_out), 32'd0);
                check({p, "_done_busy"},  32'(bus.busy_out),  32'd0);
                @(negedge clk);
                check({p, "_single_xfer"}, 32'(bus.valid_out), 32'd0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        bus.busy_in  = 1'b0;
        bus.v0x = '0; bus.v0y = '0; bus.v1x = '0; bus.v1y = '0; bus.v2x = '0; bus.v2y = '0;
        #12;
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_busy",  32'(bus.busy_out),  32'd0);
        check("rst_area",  32'(bus.area),      32'd0);
        check("rst_w0",    32'(bus.w0_row),    32'd0);
        check("rst_col0",  32'(bus.dl_w0_col), 32'd0);
        check("rst_xmax",  32'(bus.x_max),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Right triangle, counter-clockwise
        set_tri(0, 0, 64, 0, 0, 64);
        run_tri("basic", 0);
        check("basic_area_256", 32'(bus.area),      32'd256);
        check("basic_w0_256",   32'(bus.w0_row),    32'd256);
        check("basic_col0",     32'(bus.dl_w0_col), 32'h1FFC0);
        check("basic_row2",     32'(bus.dl_w2_row), 32'd64);
        check("basic_xmax4",    32'(bus.x_max),     32'd4);

        // Same triangle with opposite winding
        set_tri(0, 0, 0, 64, 64, 0);
        run_tri("swap", 0);
        check("swap_area_256", 32'(bus.area), 32'd256);

        // Degenerate
        set_tri(0, 0, 64, 0, 128, 0);
        run_tri("collinear", 0);

        // Clamp and off-screen
        set_tri(0, 0, 700 * 16, 0, 0, 64);
        run_tri("clampx", 0);
        check("clampx_639", 32'(bus.x_max), 32'd639);
        set_tri(640 * 16, 0, 650 * 16, 0, 640 * 16, 64);
        run_tri("offscreen", 0);
        set_tri(0, 490 * 16, 64, 500 * 16, 0, 510 * 16);
        run_tri("offscreen_y", 0);

        // Consumer stall
        set_tri(0, 0, 64, 0, 0, 64);
        run_tri("stall", 5);

        // Reset while multiplying (count 3)
        set_tri(16, 16, 320, 48, 100, 400);
        present(1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.valid_out), 32'd0);
        check("midrst_busy",  32'(bus.busy_out),  32'd0);
        check("midrst_area",  32'(bus.area),      32'd0);
        check("midrst_xmax",  32'(bus.x_max),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_tri(0, 0, 64, 0, 0, 64);
        run_tri("after_rst", 0);

        // Random triangles
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    tvx[i] = int'($urandom_range(0, 65535));
                    tvy[i] = int'($urandom_range(0, 65535));
                end else begin
                    tvx[i] = int'($urandom_range(0, 720 * 16));
                    tvy[i] = int'($urandom_range(0, 520 * 16));
                end
            end
            run_tri("rand", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
